// File: rtl/bus_request_arbiter_if.sv
// Requester and bus-side signals of bus_request_arbiter, bundled as one interface.
// master: the arbiter's view; slave: the requesters and bus_interface_unit together.
interface bus_request_arbiter_if;
   logic        i_code_vaild;
   logic        o_code_ready;
   logic [31:0] i_code_address;
   logic [31:0] o_code_data_read;

   logic        i_data_vaild;
   logic        i_data_write;
   logic [31:0] i_data_address;
   logic [31:0] i_data_write_data;
   logic        o_data_ready;
   logic [31:0] o_data_data_read;

   logic        o_bus_vaild;
   logic        o_bus_write;
   logic [31:0] o_bus_address;
   logic [31:0] o_bus_write_data;
   logic        i_bus_ready;
   logic [31:0] i_bus_data_read;
   logic        o_bus_error;

   modport master (
      input  i_code_vaild, i_code_address,
      input  i_data_vaild, i_data_write, i_data_address, i_data_write_data,
      input  i_bus_ready, i_bus_data_read,
      output o_code_ready, o_code_data_read,
      output o_data_ready, o_data_data_read,
      output o_bus_vaild, o_bus_write, o_bus_address, o_bus_write_data, o_bus_error
   );

   modport slave (
      output i_code_vaild, i_code_address,
      output i_data_vaild, i_data_write, i_data_address, i_data_write_data,
      output i_bus_ready, i_bus_data_read,
      input  o_code_ready, o_code_data_read,
      input  o_data_ready, o_data_data_read,
      input  o_bus_vaild, o_bus_write, o_bus_address, o_bus_write_data, o_bus_error
   );
endinterface

// File: rtl/bus_request_arbiter.sv
// Two-requester bus arbiter: data has priority, a streak counter guarantees code progress.
// Optional bus wait timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_request_arbiter #(
   parameter int unsigned FAIRNESS_LIMIT = 3,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic                   clock,
   input logic                   reset,
   bus_request_arbiter_if.master arb_if
);

   localparam int unsigned STREAK_W = (FAIRNESS_LIMIT < 1) ? 1 : $clog2(FAIRNESS_LIMIT + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(FAIRNESS_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_CODE,
      BUSY_DATA,
      RESPOND
   } state_t;

   state_t              state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                bus_vaild_q, bus_vaild_d;
   logic                bus_write_q, bus_write_d;
   logic [31:0]         bus_address_q, bus_address_d;
   logic [31:0]         bus_write_data_q, bus_write_data_d;
   logic                code_ready_q, code_ready_d;
   logic                data_ready_q, data_ready_d;
   logic [31:0]         code_data_q, code_data_d;
   logic [31:0]         data_data_q, data_data_d;
   logic                grant_data, grant_code;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              bus_error_q, bus_error_d;
`endif

   always_comb begin
      state_d          = state_q;
      streak_d         = streak_q;
      bus_vaild_d      = bus_vaild_q;
      bus_write_d      = bus_write_q;
      bus_address_d    = bus_address_q;
      bus_write_data_d = bus_write_data_q;
      code_ready_d     = 1'b0;
      data_ready_d     = 1'b0;
      code_data_d      = code_data_q;
      data_data_d      = data_data_q;
      grant_data       = 1'b0;
      grant_code       = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      wait_d           = wait_q;
      bus_error_d      = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            // Data wins unless code has already been passed over FAIRNESS_LIMIT times.
            if (arb_if.i_data_vaild && (!arb_if.i_code_vaild || streak_q < STREAK_MAX)) begin
               grant_data = 1'b1;
            end else if (arb_if.i_code_vaild) begin
               grant_code = 1'b1;
            end

            if (grant_data) begin
               bus_vaild_d      = 1'b1;
               bus_write_d      = arb_if.i_data_write;
               bus_address_d    = arb_if.i_data_address;
               bus_write_data_d = arb_if.i_data_write_data;
               state_d          = BUSY_DATA;
               if (!arb_if.i_code_vaild) begin
                  streak_d = '0;
               end else if (streak_q != STREAK_MAX) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (grant_code) begin
               bus_vaild_d      = 1'b1;
               bus_write_d      = 1'b0;
               bus_address_d    = arb_if.i_code_address;
               bus_write_data_d = '0;
               state_d          = BUSY_CODE;
               streak_d         = '0;
            end else begin
               streak_d = '0;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            wait_d = '0;
`endif
         end

         BUSY_CODE, BUSY_DATA: begin
            if (arb_if.i_bus_ready) begin
               bus_vaild_d = 1'b0;
               state_d     = RESPOND;
               if (state_q == BUSY_CODE) begin
                  code_data_d  = arb_if.i_bus_data_read;
                  code_ready_d = 1'b1;
               end else begin
                  data_data_d  = arb_if.i_bus_data_read;
                  data_ready_d = 1'b1;
               end
`ifdef BUS_ARB_TIMEOUT_EN
            end else if (wait_q == WAIT_MAX) begin
               // Abandon the bus and complete the owner with zero data.
               bus_vaild_d = 1'b0;
               bus_error_d = 1'b1;
               state_d     = RESPOND;
               if (state_q == BUSY_CODE) begin
                  code_data_d  = '0;
                  code_ready_d = 1'b1;
               end else begin
                  data_data_d  = '0;
                  data_ready_d = 1'b1;
               end
            end else begin
               wait_d = wait_q + 1'b1;
`endif
            end
         end

         RESPOND: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and all registered outputs; reset drops any transaction in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         streak_q         <= '0;
         bus_vaild_q      <= 1'b0;
         bus_write_q      <= 1'b0;
         bus_address_q    <= '0;
         bus_write_data_q <= '0;
         code_ready_q     <= 1'b0;
         data_ready_q     <= 1'b0;
         code_data_q      <= '0;
         data_data_q      <= '0;
      end else begin
         state_q          <= state_d;
         streak_q         <= streak_d;
         bus_vaild_q      <= bus_vaild_d;
         bus_write_q      <= bus_write_d;
         bus_address_q    <= bus_address_d;
         bus_write_data_q <= bus_write_data_d;
         code_ready_q     <= code_ready_d;
         data_ready_q     <= data_ready_d;
         code_data_q      <= code_data_d;
         data_data_q      <= data_data_d;
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_q      <= '0;
         bus_error_q <= 1'b0;
      end else begin
         wait_q      <= wait_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign arb_if.o_bus_error = bus_error_q;
`else
   assign arb_if.o_bus_error = 1'b0;
`endif

   assign arb_if.o_code_ready     = code_ready_q;
   assign arb_if.o_code_data_read = code_data_q;
   assign arb_if.o_data_ready     = data_ready_q;
   assign arb_if.o_data_data_read = data_data_q;
   assign arb_if.o_bus_vaild      = bus_vaild_q;
   assign arb_if.o_bus_write      = bus_write_q;
   assign arb_if.o_bus_address    = bus_address_q;
   assign arb_if.o_bus_write_data = bus_write_data_q;

endmodule

// File: doc/bus_request_arbiter.md
Name: bus_request_arbiter

Overview:
- Shares the single bus_interface_unit port between two requesters: instruction_fetch (code reads) and the execute unit (data reads/writes).
- Accepts one transaction at a time, forwards the latched address, write flag and write data to the bus, then returns the read data and a one-cycle ready pulse to the winning requester.
- Data requests have priority. A fairness counter bounds code starvation.
- Sits between instruction_fetch/execute and bus_interface_unit.

Parameters:
- FAIRNESS_LIMIT, 3: maximum consecutive data grants while a code request is pending; the next grant goes to code.
- TIMEOUT_CYCLES, 255: bus wait limit, used only with the optional feature.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- i_code_vaild  input  1  fetch request; held high until o_code_ready
- o_code_ready  output  1  one-cycle pulse; o_code_data_read is valid
- i_code_address  input  32  fetch physical address
- o_code_data_read  output  32  fetched dword
- i_data_vaild  input  1  execute request; held high until o_data_ready
- i_data_write  input  1  1 = write, 0 = read
- i_data_address  input  32  data physical address
- i_data_write_data  input  32  write dword
- o_data_ready  output  1  one-cycle completion pulse
- o_data_data_read  output  32  read dword
- o_bus_vaild  output  1  request to bus_interface_unit
- o_bus_write  output  1  write flag to bus
- o_bus_address  output  32  latched address
- o_bus_write_data  output  32  latched write data
- i_bus_ready  input  1  bus completion, one cycle
- i_bus_data_read  input  32  bus read data, valid with i_bus_ready
- o_bus_error  output  1  timeout pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values: all outputs 0, state IDLE, streak counter 0, o_code_data_read and o_data_data_read 0.
- States: IDLE, BUSY_CODE, BUSY_DATA, RESPOND.
- IDLE, arbitration on sampled valids:
  - Data only: grant data.
  - Code only: grant code.
  - Both valid: grant data if streak < FAIRNESS_LIMIT, else grant code.
- On a grant at the clock edge:
  - Latch address, write flag (code grants force write = 0) and write data into the o_bus_* registers.
  - Set o_bus_vaild = 1 and move to BUSY_CODE or BUSY_DATA.
- Streak counter:
  - Increments on a data grant while i_code_vaild = 1, saturating at FAIRNESS_LIMIT.
  - Clears on a code grant, or on any IDLE cycle with i_code_vaild = 0.
- BUSY_x: o_bus_* outputs stay stable. On i_bus_ready:
  - o_bus_vaild <= 0.
  - Capture i_bus_data_read into the owner's read-data register. Writes also capture, and the value is don't-care.
  - Owner's ready <= 1; go to RESPOND.
- RESPOND: lasts exactly one cycle with ready high, then ready <= 0 and return to IDLE. Requesters drop or update valid at this edge, so a stale valid is never re-granted.
- Latency: valid seen in IDLE at cycle t, bus request at t+1. Bus ready at cycle t+k gives requester ready at t+k+1. Back-to-back throughput is one transaction per 3 cycles minimum.
- Requester valid dropping mid-transaction: the bus transaction still completes and the ready pulse still issues.
- Read data registers hold their value until the next completion for the same requester.
- Reset mid-transaction: immediate return to IDLE, o_bus_vaild = 0, no ready pulse.

Optional Feature:
- Macro BUS_ARB_TIMEOUT_EN.
- When defined, a wait counter runs in BUSY_x:
  - It clears on entry to BUSY_x.
  - If it reaches TIMEOUT_CYCLES without i_bus_ready: o_bus_vaild <= 0, o_bus_error pulses for one cycle, the owner's ready pulses with read data 0, and the state goes to RESPOND.
- When undefined: no counter, o_bus_error is constant 0, and the arbiter waits indefinitely.

Test Plan:
1. Code-only read: i_code_address=0x0000FFF0, bus ready 2 cycles after o_bus_vaild with data 0x90909090 -> o_bus_address=0x0000FFF0, o_bus_write=0, o_code_ready pulses once with o_code_data_read=0x90909090.
2. Simultaneous: both valid, data write 0x12345678 to 0x00001000 -> data granted first (o_bus_write=1, o_bus_write_data=0x12345678), code granted next.
3. Fairness: data and code held valid continuously, FAIRNESS_LIMIT=3 -> grant sequence data, data, data, code, data…
4. Reset asserted during BUSY_DATA -> o_bus_vaild=0 immediately, no o_data_ready. After release, a new code request is served normally.
5. Late i_bus_ready with inputs changing (i_data_address altered mid-wait) -> o_bus_address stays at the latched value until completion.
6. With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, bus never ready -> o_bus_error and o_code_ready pulse 9 cycles after grant, o_code_data_read=0, arbiter returns to IDLE.
